alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_ctrl_pkg.sv | 41 ++++
 rtl/rr_arbiter_2.sv | 43 ++++
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU arbiter: opcode constants, the controller
// state encoding, the divide-by-zero response value and a small opcode
// legality helper.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALU opcodes as presented on reqN_op / alu_op
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b101;

    // Result returned for a divide whose divisor is zero
    localparam logic [63:0] DIV0_RESULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // Width of the latency counter; holds L-1 for L up to 15
    localparam int CNT_W = 4;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // How the response of the in-flight operation is produced
    typedef enum logic [1:0] {
        K_ALU     = 2'd0,   // take alu_result / alu_zero
        K_DIV0    = 2'd1,   // divide by zero: fixed all-ones, not zero
        K_ILLEGAL = 2'd2    // unknown opcode: fixed zero result
    } kind_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_DIV) || (op == OP_PASS);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. A lone requester is always granted; when both
// request, the one that was not granted last wins. After reset req[0] has
// priority.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   req     : request vector (bit N = requester N)
//   update  : the current grant was consumed; advance the priority pointer
//   grant   : one-hot (or zero) grant, combinational from req
// ---------------------------------------------------------------------------
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // 1 when requester 1 wins a tie, i.e. requester 0 was granted last
    logic r_prio1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio1 <= 1'b0;
        end else if (update) begin
            r_prio1 <= grant[0];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_prio1 ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one external ALU between two requesters. One operation is in flight
// at a time: IDLE accepts a request chosen round-robin, EXEC waits the
// opcode's settle latency, RESP holds the response until rsp_ready.
//
// Parameters
//   MUL_CYCLES : settle cycles for multiply (1..15)
//   DIV_CYCLES : settle cycles for divide   (1..15)
//
// Ports
//   clk, rst_n              : clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready : request handshake for requester N (N = 0, 1)
//   reqN_op, reqN_a, reqN_b : opcode and 64-bit operands
//   alu_a, alu_b, alu_op    : registered drive to the shared ALU
//   alu_result, alu_zero    : combinational return from the ALU
//   rsp_valid / rsp_ready   : response handshake
//   rsp_id                  : requester the response belongs to
//   rsp_result, rsp_zero    : response payload
//   busy                    : an operation is in flight (state not IDLE)
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,

    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [63:0] alu_result,
    input  logic        alu_zero,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_result,
    output logic        rsp_zero,

    output logic        busy
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    kind_t             r_kind;
    logic [63:0]       r_alu_a;
    logic [63:0]       r_alu_b;
    logic [2:0]        r_alu_op;
    logic              r_rsp_id;
    logic [63:0]       r_rsp_result;
    logic              r_rsp_zero;

    logic [1:0]        w_grant;
    logic [1:0]        w_ready;
    logic              w_accept;
    logic              w_sel1;
    logic [2:0]        w_op;
    logic [63:0]       w_a;
    logic [63:0]       w_b;
    kind_t             w_kind;
    logic [CNT_W-1:0]  w_lat_m1;

    rr_arbiter_2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .update (w_accept),
        .grant  (w_grant)
    );

    // Operand selection follows the grant
    assign w_sel1 = w_grant[1];
    assign w_op   = w_sel1 ? req1_op : req0_op;
    assign w_a    = w_sel1 ? req1_a  : req0_a;
    assign w_b    = w_sel1 ? req1_b  : req0_b;

    // Response source and counter preload (L-1) for the selected request.
    // Divide by zero and illegal opcodes never wait on the ALU, so L = 1.
    always_comb begin
        w_kind   = K_ALU;
        w_lat_m1 = '0;
        if (!is_legal_op(w_op)) begin
            w_kind = K_ILLEGAL;
        end else if ((w_op == OP_DIV) && (w_b == 64'd0)) begin
            w_kind = K_DIV0;
        end else if (w_op == OP_MUL) begin
            w_lat_m1 = CNT_W'(MUL_CYCLES - 1);
        end else if (w_op == OP_DIV) begin
            w_lat_m1 = CNT_W'(DIV_CYCLES - 1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs.
    // Ready is qualified by rst_n so both ready outputs are 0 while reset
    // is held even though the state is already IDLE.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 2'b00;
        w_accept     = 1'b0;
        busy         = (r_state != ST_IDLE);
        rsp_valid    = (r_state == ST_RESP);
        case (r_state)
            ST_IDLE: begin
                w_ready  = w_grant & {2{rst_n}};
                w_accept = |w_ready;
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Ready stays low here, so nothing is accepted on the
                // completion edge; IDLE is re-entered first.
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on acceptance, count down and capture the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_id     <= 1'b0;
            r_cnt        <= '0;
            r_kind       <= K_ALU;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else if (w_accept) begin
            r_alu_a  <= w_a;
            r_alu_b  <= w_b;
            r_alu_op <= w_op;
            r_rsp_id <= w_sel1;
            r_cnt    <= w_lat_m1;
            r_kind   <= w_kind;
        end else if (r_state == ST_EXEC) begin
            if (r_cnt == '0) begin
                case (r_kind)
                    K_DIV0: begin
                        r_rsp_result <= DIV0_RESULT;
                        r_rsp_zero   <= 1'b0;
                    end
                    K_ILLEGAL: begin
                        r_rsp_result <= '0;
                        r_rsp_zero   <= 1'b1;
                    end
                    default: begin
                        r_rsp_result <= alu_result;
                        r_rsp_zero   <= alu_zero;
                    end
                endcase
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed bench for alu_arbiter with a stand-in ALU, a transaction-level
// reference model checked every cycle, and literal expectations per scenario.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int MULC = 2;
    localparam int DIVC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [63:0] rsp_result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    // Stand-in ALU; returns junk for div-by-zero and illegal opcodes so the
    // block's own override is what gets observed.
    always_comb begin
        case (alu_op)
            3'b010:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b100:  alu_result = alu_a * alu_b;
            3'b011:  alu_result = (alu_b != 64'd0) ? alu_a / alu_b : 64'hDEAD_BEEF;
            3'b101:  alu_result = alu_a;
            default: alu_result = 64'h5A5A_5A5A_5A5A_5A5A;
        endcase
        alu_zero = (alu_result == 64'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_op(input logic [2:0] op, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] r,
                                     output int lat);
        lat = 1;
        case (op)
            3'b010: r = a + b;
            3'b001: r = a - b;
            3'b100: begin r = a * b; lat = MULC; end
            3'b011: begin
                if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF;
                else begin r = a / b; lat = DIVC; end
            end
            3'b101: r = a;
            default: r = 64'd0;
        endcase
    endfunction

    logic        m_busy  = 1'b0;
    int          m_wait  = 0;      // cycles until the response is due
    logic        m_prio1 = 1'b0;   // requester 1 wins a tie
    logic        m_id    = 1'b0;
    logic [2:0]  m_op    = 3'd0;
    logic [63:0] m_a     = 64'd0;
    logic [63:0] m_b     = 64'd0;
    logic [63:0] m_res   = 64'd0;
    logic        g0, g1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_wait  = 0;
            m_prio1 = 1'b0;
        end else if (!m_busy) begin
            g0 = req0_valid && !(req1_valid && m_prio1);
            g1 = req1_valid && !(req0_valid && !m_prio1);
            if (g0 || g1) begin
                m_busy  = 1'b1;
                m_id    = g1;
                m_op    = g1 ? req1_op : req0_op;
                m_a     = g1 ? req1_a  : req0_a;
                m_b     = g1 ? req1_b  : req0_b;
                model_op(m_op, m_a, m_b, m_res, m_wait);
                m_prio1 = !g1;
            end
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end else if (rsp_ready) begin
            m_busy = 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst ready0", 64'(req0_ready), 64'd0);
            chk("rst ready1", 64'(req1_ready), 64'd0);
            chk("rst busy", 64'(busy), 64'd0);
            chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        end else begin
            chk("cmp busy", 64'(busy), 64'(m_busy));
            chk("cmp rsp_valid", 64'(rsp_valid), 64'(m_busy && (m_wait == 0)));
            chk("cmp ready0", 64'(req0_ready),
                64'(!m_busy && req0_valid && !(req1_valid && m_prio1)));
            chk("cmp ready1", 64'(req1_ready),
                64'(!m_busy && req1_valid && !(req0_valid && !m_prio1)));
            if (m_busy) begin
                chk("cmp alu_op", 64'(alu_op), 64'(m_op));
                chk("cmp alu_a", alu_a, m_a);
                chk("cmp alu_b", alu_b, m_b);
                chk("cmp rsp_id", 64'(rsp_id), 64'(m_id));
                if (m_wait == 0) begin
                    chk("cmp rsp_result", rsp_result, m_res);
                    chk("cmp rsp_zero", 64'(rsp_zero), 64'(m_res == 64'd0));
                end
            end
        end
    end

    // ---------------- transaction monitor ----------------
    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        zero;
        int          lat;
    } rsp_rec_t;

    rsp_rec_t rsp_q[$];
    int   cyc       = 0;
    int   acc_edge  = 0;
    int   lat_meas  = 0;
    int   n_rv_rise = 0;
    logic prev_rv   = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rv = 1'b0;
        end else begin
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready))
                acc_edge = cyc + 1;
            if (rsp_valid && !prev_rv) begin
                lat_meas = cyc - acc_edge;
                n_rv_rise++;
            end
            if (rsp_valid && rsp_ready) begin
                rsp_q.push_back('{id: rsp_id, res: rsp_result, zero: rsp_zero, lat: lat_meas});
                $display("txn id=%0d result=%0h zero=%0d latency=%0d",
                         rsp_id, rsp_result, rsp_zero, lat_meas);
            end
            prev_rv = rsp_valid;
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end at posedge+1.
    task automatic send(input logic id, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b);
        logic done;
        done = 1'b0;
        if (!id) begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; end
        else     begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1; end
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = id ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
            @(posedge clk); #1;
        end
        if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL send req%0d: not accepted within 200 cycles, expected acceptance", id);
        end
    endtask

    task automatic send_pair(input logic [2:0] op0, input logic [63:0] a0, input logic [63:0] b0,
                             input logic [2:0] op1, input logic [63:0] a1, input logic [63:0] b1);
        logic d0, d1, acc0, acc1;
        d0 = 1'b0; d1 = 1'b0;
        req0_op = op0; req0_a = a0; req0_b = b0; req0_valid = 1'b1;
        req1_op = op1; req1_a = a1; req1_b = b1; req1_valid = 1'b1;
        for (int i = 0; i < 200 && !(d0 && d1); i++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (acc0) begin req0_valid = 1'b0; d0 = 1'b1; end
            if (acc1) begin req1_valid = 1'b0; d1 = 1'b1; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (!(d0 && d1)) begin
            n_checks++; n_errors++;
            $display("FAIL send_pair: accepted req0=%0d req1=%0d, expected both", d0, d1);
        end
    endtask

    task automatic expect_rsp(input string name, input logic id, input logic [63:0] res,
                              input logic zero, input int lat);
        rsp_rec_t r;
        for (int t = 0; t < 200 && rsp_q.size() == 0; t++) @(negedge clk);
        if (rsp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s timeout: got no response in 200 cycles, expected one", name);
        end else begin
            r = rsp_q.pop_front();
            chk({name, " id"},      64'(r.id),   64'(id));
            chk({name, " result"},  r.res,       res);
            chk({name, " zero"},    64'(r.zero), 64'(zero));
            chk({name, " latency"}, 64'(r.lat),  64'(lat));
        end
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    int rv_before;

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 3'd0; req1_op = 3'd0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset state, with a request offered while reset is held
        #12;
        req0_valid = 1'b1; req0_op = 3'b010;
        #1;
        chk("reset ready0", 64'(req0_ready), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset alu_op", 64'(alu_op), 64'd0);
        chk("reset rsp_result", rsp_result, 64'd0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous subs: req0 then req1, then another pair starts at req0
        send_pair(3'b001, 64'd9, 64'd9, 3'b001, 64'd9, 64'd9);
        expect_rsp("pair1 first", 1'b0, 64'd0, 1'b1, 1);
        expect_rsp("pair1 second", 1'b1, 64'd0, 1'b1, 1);
        send_pair(3'b010, 64'd1, 64'd1, 3'b010, 64'd2, 64'd2);
        expect_rsp("pair2 first", 1'b0, 64'd2, 1'b0, 1);
        expect_rsp("pair2 second", 1'b1, 64'd4, 1'b0, 1);

        // Add
        send(1'b0, 3'b010, 64'd5, 64'd7);
        expect_rsp("add 5+7", 1'b0, 64'd12, 1'b0, 1);

        // Multi-cycle mul and div
        send(1'b1, 3'b100, 64'd3, 64'd4);
        expect_rsp("mul 3*4", 1'b1, 64'd12, 1'b0, MULC);
        send(1'b0, 3'b011, 64'd100, 64'd7);
        expect_rsp("div 100/7", 1'b0, 64'd14, 1'b0, DIVC);
        send(1'b1, 3'b101, 64'd0, 64'd5);
        expect_rsp("pass 0", 1'b1, 64'd0, 1'b1, 1);

        // Divide by zero and illegal opcodes
        send(1'b0, 3'b011, 64'd8, 64'd0);
        expect_rsp("div by 0", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        send(1'b1, 3'b111, 64'd5, 64'd5);
        expect_rsp("illegal 111", 1'b1, 64'd0, 1'b1, 1);
        send(1'b0, 3'b000, 64'd3, 64'd3);
        expect_rsp("illegal 000", 1'b0, 64'd0, 1'b1, 1);

        // req0 was granted last, so a tie now goes to req1
        send_pair(3'b010, 64'd10, 64'd0, 3'b010, 64'd20, 64'd0);
        expect_rsp("rr tie first", 1'b1, 64'd20, 1'b0, 1);
        expect_rsp("rr tie second", 1'b0, 64'd10, 1'b0, 1);

        // Back-pressure on the response
        rsp_ready = 1'b0;
        send(1'b0, 3'b010, 64'd1, 64'd2);
        req1_op = 3'b101; req1_a = 64'd42; req1_b = 64'd0; req1_valid = 1'b1;
        for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("hold rsp_valid", 64'(rsp_valid), 64'd1);
            chk("hold rsp_result", rsp_result, 64'd3);
            chk("hold rsp_id", 64'(rsp_id), 64'd0);
            chk("hold busy", 64'(busy), 64'd1);
            chk("hold ready1", 64'(req1_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(1'b1, 3'b101, 64'd42, 64'd0);
        expect_rsp("held add", 1'b0, 64'd3, 1'b0, 1);
        expect_rsp("after hold pass", 1'b1, 64'd42, 1'b0, 1);

        // Reset in the middle of a divide
        send(1'b0, 3'b011, 64'd100, 64'd7);
        @(posedge clk);
        @(negedge clk); #2;
        rv_before = n_rv_rise;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 3'b010;
        #1;
        chk("async busy", 64'(busy), 64'd0);
        chk("async rsp_valid", 64'(rsp_valid), 64'd0);
        chk("async ready0", 64'(req0_ready), 64'd0);
        chk("async alu_a", alu_a, 64'd0);
        chk("async alu_b", alu_b, 64'd0);
        chk("async alu_op", 64'(alu_op), 64'd0);
        chk("async rsp_result", rsp_result, 64'd0);
        chk("async rsp_zero", 64'(rsp_zero), 64'd0);
        chk("async rsp_id", 64'(rsp_id), 64'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no rsp after reset", 64'(n_rv_rise - rv_before), 64'd0);
        chk("no txn after reset", 64'(rsp_q.size()), 64'd0);

        // Priority pointer back at req0 after reset
        send_pair(3'b010, 64'd7, 64'd0, 3'b010, 64'd8, 64'd0);
        expect_rsp("post-reset first", 1'b0, 64'd7, 1'b0, 1);
        expect_rsp("post-reset second", 1'b1, 64'd8, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
